// File: rtl/oport_credit_pipe.sv
// Output-port credit pipe for a NoC router.
// Delays crossbar flits by PIPE_STAGES cycles and keeps one downstream credit
// counter and one packet-ownership FSM per output VC. It also reports
// per-port congestion and latches any protocol error until reset.
module oport_credit_pipe #(
    parameter int V           = 4,
    parameter int P           = 5,
    parameter int B           = 4,
    parameter int Fpay        = 32,
    parameter int PIPE_STAGES = 1,
    parameter int CONGw       = 3,
    localparam int Fw         = 2 + V + Fpay,
    localparam int PV         = P * V,
    localparam int CNTw       = $clog2(B + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [P*Fw-1:0]      flit_in_all,
    input  logic [P-1:0]         flit_in_we_all,
    input  logic [PV-1:0]        credit_in_all,
    output logic [P*Fw-1:0]      flit_out_all,
    output logic [P-1:0]         flit_out_we_all,
    output logic [PV-1:0]        ovc_not_full_all,
    output logic [PV-1:0]        ovc_allocated_all,
    output logic [P*CONGw-1:0]   congestion_out_all,
    output logic [P-1:0]         err_all
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} ovc_state_t;

    localparam logic [CNTw-1:0] FULL     = CNTw'(B);
    localparam logic [CNTw-1:0] ONE      = CNTw'(1);
    localparam logic [V-1:0]    OVC_ONE  = V'(1);
    localparam int              CONG_MAX = (1 << CONGw) - 1;

    logic [CNTw-1:0]    cnt        [PV];
    logic [CNTw-1:0]    cnt_next   [PV];
    ovc_state_t         state      [PV];
    ovc_state_t         state_next [PV];
    logic [P-1:0]       err_next;
    logic [P*CONGw-1:0] cong_next;

    logic [P-1:0]       head;
    logic [P-1:0]       tail;
    logic [P-1:0]       onehot;
    logic [V-1:0]       ovc [P];

    // Field decode of each incoming flit; OVC must be exactly one-hot to count.
    for (genvar g = 0; g < P; g++) begin : g_dec
        assign head[g]   = flit_in_all[g*Fw + Fw - 1];
        assign tail[g]   = flit_in_all[g*Fw + Fw - 2];
        assign ovc[g]    = flit_in_all[g*Fw + Fpay +: V];
        assign onehot[g] = (ovc[g] != '0) && ((ovc[g] & (ovc[g] - OVC_ONE)) == '0);
    end

    // Flit path: plain wires when no stages are requested, otherwise a shift
    // register where only the valid bits are reset.
    if (PIPE_STAGES == 0) begin : g_comb
        assign flit_out_all    = flit_in_all;
        assign flit_out_we_all = flit_in_we_all;
    end else begin : g_pipe
        logic [P*Fw-1:0] flit_p [PIPE_STAGES];
        logic [P-1:0]    vld_p  [PIPE_STAGES];

        // Valid shift chain; cleared on reset so in-flight flits are dropped.
        always_ff @(posedge clk) begin
            if (!reset) begin
                for (int s = 0; s < PIPE_STAGES; s++) vld_p[s] <= '0;
            end else begin
                vld_p[0] <= flit_in_we_all;
                for (int s = 1; s < PIPE_STAGES; s++) vld_p[s] <= vld_p[s-1];
            end
        end

        // Data shift chain; no reset needed because valid qualifies it.
        always_ff @(posedge clk) begin
            flit_p[0] <= flit_in_all;
            for (int s = 1; s < PIPE_STAGES; s++) flit_p[s] <= flit_p[s-1];
        end

        assign flit_out_all    = flit_p[PIPE_STAGES-1];
        assign flit_out_we_all = vld_p[PIPE_STAGES-1];
    end

    // Next-state for credit counters, OVC FSMs and the sticky error flags.
    // The counter is charged at pipe entry so that flits still in flight
    // already hold their credit.
    always_comb begin
        err_next = err_all;
        for (int i = 0; i < PV; i++) begin
            cnt_next[i]   = cnt[i];
            state_next[i] = state[i];
        end
        for (int p = 0; p < P; p++) begin
            if (flit_in_we_all[p] && !onehot[p]) err_next[p] = 1'b1;
            for (int v = 0; v < V; v++) begin
                if (flit_in_we_all[p] && onehot[p] && ovc[p][v] && !credit_in_all[p*V+v]) begin
                    if (cnt[p*V+v] == '0) err_next[p] = 1'b1;
                    else                  cnt_next[p*V+v] = cnt[p*V+v] - ONE;
                end else if (credit_in_all[p*V+v] &&
                             !(flit_in_we_all[p] && onehot[p] && ovc[p][v])) begin
                    if (cnt[p*V+v] == FULL) err_next[p] = 1'b1;
                    else                    cnt_next[p*V+v] = cnt[p*V+v] + ONE;
                end
                if (flit_in_we_all[p] && onehot[p] && ovc[p][v]) begin
                    case ({head[p], tail[p]})
                        2'b10: begin
                            if (state[p*V+v] == IDLE) state_next[p*V+v] = BUSY;
                            else                      err_next[p] = 1'b1;
                        end
                        2'b11: begin
                            if (state[p*V+v] == BUSY) err_next[p] = 1'b1;
                        end
                        2'b01: begin
                            if (state[p*V+v] == BUSY) state_next[p*V+v] = IDLE;
                            else                      err_next[p] = 1'b1;
                        end
                        default: begin
                            if (state[p*V+v] == IDLE) err_next[p] = 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    // Congestion: number of exhausted VCs per port, saturated to the field.
    always_comb begin
        int zc;
        zc        = 0;
        cong_next = '0;
        for (int p = 0; p < P; p++) begin
            zc = 0;
            for (int v = 0; v < V; v++) begin
                if (cnt[p*V+v] == '0) zc = zc + 1;
            end
            cong_next[p*CONGw +: CONGw] = (zc > CONG_MAX) ? CONGw'(CONG_MAX) : CONGw'(zc);
        end
    end

    // Control state registers; reset overrides any flit or credit input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < PV; i++) begin
                cnt[i]   <= FULL;
                state[i] <= IDLE;
            end
            err_all            <= '0;
            congestion_out_all <= '0;
        end else begin
            for (int i = 0; i < PV; i++) begin
                cnt[i]   <= cnt_next[i];
                state[i] <= state_next[i];
            end
            err_all            <= err_next;
            congestion_out_all <= cong_next;
        end
    end

    for (genvar g = 0; g < PV; g++) begin : g_flags
        assign ovc_not_full_all[g]  = (cnt[g] != '0);
        assign ovc_allocated_all[g] = (state[g] == BUSY);
    end

endmodule

// File: tb/tb_oport_credit_pipe.sv
// Directed bench for oport_credit_pipe: a 2-stage build and a 0-stage build
// driven by the same stimulus, with hand-computed expectations.
module tb_oport_credit_pipe;

    localparam int V     = 2;
    localparam int P     = 2;
    localparam int B     = 4;
    localparam int FPAY  = 8;
    localparam int CONGW = 3;
    localparam int FW    = 2 + V + FPAY;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [FW-1:0]     f0, f1;
    logic [1:0]        we;
    logic [3:0]        cr;
    logic [2*FW-1:0]   fin;
    assign fin = {f1, f0};

    logic [2*FW-1:0]   fout, zout;
    logic [1:0]        fwe, zwe, er, zer;
    logic [3:0]        nf, al, znf, zal;
    logic [5:0]        cg, zcg;

    int n_cmp = 0;
    int n_err = 0;

    oport_credit_pipe #(.V(V), .P(P), .B(B), .Fpay(FPAY), .PIPE_STAGES(2), .CONGw(CONGW)) dut (
        .clk(clk), .reset(reset),
        .flit_in_all(fin), .flit_in_we_all(we), .credit_in_all(cr),
        .flit_out_all(fout), .flit_out_we_all(fwe),
        .ovc_not_full_all(nf), .ovc_allocated_all(al),
        .congestion_out_all(cg), .err_all(er)
    );

    oport_credit_pipe #(.V(V), .P(P), .B(B), .Fpay(FPAY), .PIPE_STAGES(0), .CONGw(CONGW)) dz (
        .clk(clk), .reset(reset),
        .flit_in_all(fin), .flit_in_we_all(we), .credit_in_all(cr),
        .flit_out_all(zout), .flit_out_we_all(zwe),
        .ovc_not_full_all(znf), .ovc_allocated_all(zal),
        .congestion_out_all(zcg), .err_all(zer)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic h, input logic t,
                                         input logic [1:0] o, input logic [7:0] pay);
        return {h, t, o, pay};
    endfunction

    // Advance one clock edge, then return flit/credit strobes to idle.
    task automatic step();
        @(posedge clk);
        #1;
        we = '0;
        cr = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [FW-1:0] hd, bd, tl, nh;
        reset = 1'b0; we = '0; cr = '0; f0 = '0; f1 = '0;
        step(); step();
        reset = 1'b1;

        check("rst_we",    fwe, 2'b00);
        check("rst_nf",    nf,  4'b1111);
        check("rst_alloc", al,  4'b0000);
        check("rst_cong",  cg,  6'd0);
        check("rst_err",   er,  2'b00);

        // Three-flit packet on port0 VC0.
        hd = mk(1'b1, 1'b0, 2'b01, 8'hA1);
        bd = mk(1'b0, 1'b0, 2'b01, 8'hA2);
        tl = mk(1'b0, 1'b1, 2'b01, 8'hA3);
        f0 = hd; we = 2'b01; #1;
        check("p0_comb_flit", zout[FW-1:0], hd);
        check("p0_comb_we",   zwe, 2'b01);
        step();
        check("pkt_alloc_head", al,  4'b0001);
        check("p0_alloc_head",  zal, 4'b0001);
        check("pkt_we_e1",      fwe, 2'b00);
        f0 = bd; we = 2'b01; step();
        check("pkt_we_e2",   fwe, 2'b01);
        check("pkt_out_head", fout[FW-1:0], hd);
        f0 = tl; we = 2'b01; step();
        check("pkt_out_body",   fout[FW-1:0], bd);
        check("pkt_alloc_tail", al, 4'b0000);
        check("pkt_nf_cnt1",    nf, 4'b1111);
        step();
        check("pkt_out_tail", fout[FW-1:0], tl);
        check("pkt_we_e4",    fwe, 2'b01);
        step();
        check("pkt_we_e5",    fwe, 2'b00);

        // Single-flit packet drains VC0 from 1 to 0 without allocating.
        f0 = mk(1'b1, 1'b1, 2'b01, 8'hC1); we = 2'b01; step();
        check("single_alloc", al,  4'b0000);
        check("single_nf",    nf,  4'b1110);
        check("p0_single_nf", znf, 4'b1110);
        step();
        check("single_cong",    cg,  6'b000_001);
        check("p0_single_cong", zcg, 6'b000_001);
        check("single_err",     er,  2'b00);

        // Exhaust port1 VC1, then overrun it.
        for (int k = 0; k < 4; k++) begin
            f1 = mk(1'b1, 1'b1, 2'b10, 8'(k)); we = 2'b10; step();
        end
        check("exh_nf",  nf, 4'b0110);
        check("exh_err", er, 2'b00);
        f1 = mk(1'b1, 1'b1, 2'b10, 8'h55); we = 2'b10; step();
        check("ovr_err",    er,  2'b10);
        check("p0_ovr_err", zer, 2'b10);
        check("ovr_nf",     nf,  4'b0110);
        check("ovr_cong",   cg,  6'b001_001);

        // Port0 VC1: down to 2, simultaneous write+credit, then drain.
        for (int k = 0; k < 2; k++) begin
            f0 = mk(1'b1, 1'b1, 2'b10, 8'h60); we = 2'b01; step();
        end
        f0 = mk(1'b1, 1'b1, 2'b10, 8'h61); we = 2'b01; cr = 4'b0010; step();
        f0 = mk(1'b1, 1'b1, 2'b10, 8'h62); we = 2'b01; step();
        check("coin_cnt1", nf[1], 1'b1);
        f0 = mk(1'b1, 1'b1, 2'b10, 8'h63); we = 2'b01; step();
        check("coin_cnt0", nf[1], 1'b0);
        check("coin_err",  er,    2'b10);
        cr = 4'b0010; step();
        check("cred_nf", nf[1], 1'b1);
        for (int k = 0; k < 3; k++) begin
            cr = 4'b0010; step();
        end
        check("cred_full_err", er, 2'b10);
        cr = 4'b0010; step();
        check("cred_ovf_err", er, 2'b11);

        // Reset with two flits in the pipe.
        f0 = mk(1'b1, 1'b0, 2'b01, 8'hD1); we = 2'b01; step();
        f0 = mk(1'b0, 1'b0, 2'b01, 8'hD2); we = 2'b01; step();
        check("pre_rst_we", fwe, 2'b01);
        reset = 1'b0;
        f0 = mk(1'b0, 1'b1, 2'b01, 8'hD3); we = 2'b01; cr = 4'b1111; step();
        check("mid_rst_we",    fwe, 2'b00);
        check("mid_rst_nf",    nf,  4'b1111);
        check("mid_rst_alloc", al,  4'b0000);
        check("mid_rst_err",   er,  2'b00);
        check("mid_rst_cong",  cg,  6'd0);
        check("p0_rst_err",    zer, 2'b00);
        reset = 1'b1;
        step();
        check("post_rst_we",   fwe, 2'b00);
        check("post_rst_cong", cg,  6'd0);

        // Body flit to an idle VC, then a non-one-hot OVC on port1.
        f0 = mk(1'b0, 1'b0, 2'b10, 8'hE1); we = 2'b01; step();
        check("body_idle_err",   er, 2'b01);
        check("body_idle_alloc", al, 4'b0000);
        nh = mk(1'b1, 1'b0, 2'b11, 8'hE2);
        f1 = nh; we = 2'b10; step();
        check("nonoh_err",   er, 2'b11);
        check("nonoh_nf",    nf, 4'b1111);
        check("nonoh_alloc", al, 4'b0000);
        step();
        check("nonoh_fwd_we",   fwe, 2'b10);
        check("nonoh_fwd_flit", fout[2*FW-1:FW], nh);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
